// File: rtl/bldc_motor_emu_ramp.sv
// rtl/bldc_motor_emu_ramp.sv - BLDC motor emulator: PWM duty measurement, inertial speed ramp, quadrature encoder
module bldc_motor_emu_ramp #(
  parameter int DATA_WIDTH = 16,
  parameter int PWM_PERIOD = 1000,
  parameter int ACCEL      = 100,
  parameter int ACC_WIDTH  = 16,
  parameter int CPR        = 400,
  parameter int POS_WIDTH  = 9
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  motor_positive,
  input  logic                  motor_negative,
  output logic                  encoder_a,
  output logic                  encoder_b,
  output logic                  encoder_z,
  output logic [POS_WIDTH-1:0]  position,
  output logic [DATA_WIDTH-1:0] speed,
  output logic                  direction,
  output logic                  fault,
  output logic                  window_done
);

  localparam logic [DATA_WIDTH-1:0] LAST_COUNT = DATA_WIDTH'(PWM_PERIOD - 1);
  localparam logic [DATA_WIDTH-1:0] ACCEL_STEP = DATA_WIDTH'(ACCEL);
  localparam logic [POS_WIDTH-1:0]  LAST_POS   = POS_WIDTH'(CPR - 1);
  localparam logic [POS_WIDTH-1:0]  POS_ONE    = POS_WIDTH'(1);

  // Measurement window state
  logic [DATA_WIDTH-1:0] win_cnt;
  logic [DATA_WIDTH-1:0] pos_ones;
  logic [DATA_WIDTH-1:0] neg_ones;
  logic                  both_seen;

  // Samples of the current cycle, folded into the totals so the closing cycle counts
  logic                  pos_only;
  logic                  neg_only;
  logic                  both_now;
  logic                  window_close;
  logic [DATA_WIDTH-1:0] pos_total;
  logic [DATA_WIDTH-1:0] neg_total;
  logic                  both_total;

  // Window-close decision
  logic                  fault_next;
  logic                  req_dir;
  logic [DATA_WIDTH-1:0] target;
  logic [DATA_WIDTH-1:0] ramp_speed;
  logic [DATA_WIDTH-1:0] brake_speed;
  logic [DATA_WIDTH-1:0] speed_next;
  logic                  dir_next;

  // Step generation and encoder
  logic [ACC_WIDTH-1:0]  acc;
  logic [ACC_WIDTH:0]    acc_sum;
  logic                  step;
  logic [POS_WIDTH-1:0]  pos_next;
  logic [1:0]            ab_next;

  assign pos_only     = motor_positive & ~motor_negative;
  assign neg_only     = motor_negative & ~motor_positive;
  assign both_now     = motor_positive & motor_negative;
  assign window_close = (win_cnt == LAST_COUNT);
  assign pos_total    = pos_ones + DATA_WIDTH'(pos_only);
  assign neg_total    = neg_ones + DATA_WIDTH'(neg_only);
  assign both_total   = both_seen | both_now;

  assign acc_sum = {1'b0, acc} + {1'b0, ACC_WIDTH'(speed)};
  assign step    = acc_sum[ACC_WIDTH];

  // Window counter and duty accumulation; everything restarts after the closing cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      win_cnt   <= '0;
      pos_ones  <= '0;
      neg_ones  <= '0;
      both_seen <= 1'b0;
    end else if (window_close) begin
      win_cnt   <= '0;
      pos_ones  <= '0;
      neg_ones  <= '0;
      both_seen <= 1'b0;
    end else begin
      win_cnt   <= win_cnt + DATA_WIDTH'(1);
      pos_ones  <= pos_total;
      neg_ones  <= neg_total;
      both_seen <= both_total;
    end
  end

  // Requested direction and target speed from the measured duty
  always_comb begin
    fault_next = fault | both_total;
    req_dir    = direction;
    target     = '0;
    if (fault_next) begin
      req_dir = direction;
      target  = '0;
    end else if ((pos_total >= neg_total) && (pos_total != '0)) begin
      req_dir = 1'b1;
      target  = pos_total;
    end else if (neg_total != '0) begin
      req_dir = 1'b0;
      target  = neg_total;
    end
  end

  // Acceleration-limited ramp; a reversal first brakes to zero before flipping direction
  always_comb begin
    ramp_speed = speed;
    if (target > speed) begin
      ramp_speed = ((target - speed) > ACCEL_STEP) ? (speed + ACCEL_STEP) : target;
    end else if (target < speed) begin
      ramp_speed = ((speed - target) > ACCEL_STEP) ? (speed - ACCEL_STEP) : target;
    end
    brake_speed = (speed > ACCEL_STEP) ? (speed - ACCEL_STEP) : '0;
    speed_next  = ramp_speed;
    dir_next    = direction;
    if (req_dir != direction) begin
      if (speed != '0) begin
        speed_next = brake_speed;
      end else begin
        dir_next = req_dir;
      end
    end
  end

  // Register window results; visible the cycle after close alongside window_done
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      speed       <= '0;
      direction   <= 1'b1;
      fault       <= 1'b0;
      window_done <= 1'b0;
    end else begin
      window_done <= window_close;
      if (window_close) begin
        speed     <= speed_next;
        direction <= dir_next;
        fault     <= fault_next;
      end
    end
  end

  // Phase accumulator: carry-out rate is proportional to speed
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
    end else begin
      acc <= acc_sum[ACC_WIDTH-1:0];
    end
  end

  // Next position and Gray-coded A/B for one step in the current (pre-update) direction
  always_comb begin
    pos_next = position;
    ab_next  = {encoder_a, encoder_b};
    if (step) begin
      if (direction) begin
        pos_next = (position == LAST_POS) ? '0 : (position + POS_ONE);
        ab_next  = {encoder_b, ~encoder_a};
      end else begin
        pos_next = (position == '0) ? LAST_POS : (position - POS_ONE);
        ab_next  = {~encoder_b, encoder_a};
      end
    end
  end

  // Encoder outputs; index tracks the registered position exactly
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      position  <= '0;
      encoder_a <= 1'b0;
      encoder_b <= 1'b0;
      encoder_z <= 1'b1;
    end else begin
      position  <= pos_next;
      encoder_a <= ab_next[1];
      encoder_b <= ab_next[0];
      encoder_z <= (pos_next == '0);
    end
  end

endmodule

// File: doc/bldc_motor_emu_ramp.md
Name: bldc_motor_emu_ramp

Overview:
- Parametrised motor emulator for ESC testbenches and on-board self-test.
- Measures PWM duty on motor_positive/motor_negative over fixed measurement windows.
- Models inertia with an acceleration-limited speed ramp, including a forced stop before any direction reversal.
- Outputs quadrature A/B, index Z and a wrapping position count, driven from a phase accumulator so step rate is proportional to speed.

Parameters:
- DATA_WIDTH, 16: width of duty counters and speed; PWM_PERIOD < 2^DATA_WIDTH required.
- PWM_PERIOD, 1000: clocks per measurement window.
- ACCEL, 100: maximum speed change per window.
- ACC_WIDTH, 16: phase accumulator width; ACC_WIDTH >= DATA_WIDTH required.
- CPR, 400: encoder counts per revolution; position range 0..CPR-1.
- POS_WIDTH, 9: position width; 2^POS_WIDTH >= CPR required.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- motor_positive  in  1  forward PWM drive
- motor_negative  in  1  reverse PWM drive
- encoder_a  out  1  quadrature A
- encoder_b  out  1  quadrature B
- encoder_z  out  1  index, high while position==0
- position  out  POS_WIDTH  current count
- speed  out  DATA_WIDTH  current modelled speed (0..PWM_PERIOD)
- direction  out  1  1=forward, 0=reverse
- fault  out  1  sticky shoot-through flag
- window_done  out  1  one-clock pulse, cycle after each window close

Behaviour:
- Reset (reset_n low, asynchronous):
  - encoder_a=0, encoder_b=0, encoder_z=1, position=0, speed=0, direction=1, fault=0, window_done=0.
  - Window counter, duty counters and accumulator cleared.
- Window counter:
  - Counts 0..PWM_PERIOD-1, then wraps.
  - Each cycle increments pos_ones if motor_positive && !motor_negative.
  - Each cycle increments neg_ones if motor_negative && !motor_positive.
  - Sets a both_seen flag if both inputs are high.
  - The final cycle (count==PWM_PERIOD-1) is included in the sample; all counters and both_seen clear for the next window.
- Window close (count==PWM_PERIOD-1). Registered results are visible the next cycle, together with window_done=1.
  - If both_seen: fault<=1. fault stays set until reset.
  - If fault (including newly set): target=0, requested direction = current direction.
  - Else if pos_ones >= neg_ones and pos_ones > 0: request forward, target=pos_ones.
  - Else if neg_ones > 0: request reverse, target=neg_ones.
  - Else: target=0, requested direction = current direction.
- Speed update (applied at the same window close):
  - Requested direction != direction and speed > 0: speed <= max(speed-ACCEL, 0).
  - Requested direction != direction and speed == 0: direction <= requested, then ramp toward target.
  - Otherwise: speed moves toward target by at most ACCEL, never overshooting. Subtraction saturates at 0.
- Step generation:
  - Each clock, acc <= acc + speed (ACC_WIDTH, zero-extended).
  - Carry-out produces exactly one step that cycle; speed==0 produces no steps.
- Quadrature state {encoder_a, encoder_b}:
  - Forward sequence: 00 -> 01 -> 11 -> 10 -> 00.
  - Reverse sequence: exact opposite order.
  - Only one bit changes per step.
  - A direction change continues from the current state; no jump.
- Position:
  - Forward step: +1, wrapping CPR-1 -> 0.
  - Reverse step: -1, wrapping 0 -> CPR-1.
  - encoder_z is registered, equal to (position==0), and updates in the same cycle as position.
- Simultaneous events: window close and a step in the same cycle are both applied. The step uses the pre-update direction.

Test Plan:
1. Assert reset_n low mid-run with clk stopped -> all outputs at reset values immediately; encoder_z=1, speed=0, fault=0.
2. motor_positive at 50% duty (500 high clocks per 1000-clock window), defaults -> speed 100,200,300,400,500 after windows 1..5, then holds 500; steps every ~131 clocks; A/B sequence 00,01,11,10; position increments.
3. motor_positive at 100% duty -> speed reaches 1000 after 10 windows; position wraps 399 -> 0 with encoder_z=1 only while position==0.
4. At speed 300 forward, switch to motor_negative 30% duty -> speed 200,100,0 with direction=1; direction=0 at the next window; speed then ramps 100,200,300; A/B sequence 00,10,11,01; position decrements and wraps 0 -> 399.
5. Both inputs high for a single clock inside a window -> fault=1 on the window_done cycle; speed ramps down by 100 per window to 0; fault holds despite clean PWM afterwards until reset_n is pulsed.
6. Zero duty for a whole window at speed 50 -> speed 0 (no undershoot); no further steps; direction unchanged.
